// File: rtl/sample_sequencer.sv
// sample_sequencer: one ordered ADC -> filter -> DAC schedule per sample slot, with
// overrun detection (slot arriving while busy) and peripheral acknowledge timeout.
// Build option: define OVERRUN_COUNT_EN to get a saturating dropped-slot counter on
// overrun_cnt_o; otherwise overrun_cnt_o is tied to zero.
//
// state   | meaning
// IDLE    | waiting for a slot with enable_i set
// ADC_REQ | one-cycle start pulse to AdcReader
// ADC_ACK | waiting for adc_idle_i to drop (bounded by ACK_TIMEOUT)
// ADC_RUN | conversion running; capture sample when adc_idle_i returns
// FILT    | filter running; entry cycle pulses filt_start_o, wait for filt_done_i
// DAC_REQ | one-cycle start pulse to DacWriter
// DAC_ACK | waiting for dac_idle_i to drop (bounded by ACK_TIMEOUT)
// DAC_RUN | DAC write running; back to IDLE when dac_idle_i returns
module sample_sequencer #(
  parameter int PERIOD      = 32,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        enable_i,
  input  logic        bypass_i,
  input  logic        mute_i,
  output logic        adc_start_o,
  input  logic        adc_idle_i,
  input  logic [15:0] adc_data_i,
  output logic        filt_start_o,
  output logic [15:0] filt_data_o,
  input  logic        filt_done_i,
  input  logic [15:0] filt_result_i,
  output logic        dac_start_o,
  output logic [15:0] dac_data_o,
  input  logic        dac_idle_i,
  output logic        busy_o,
  output logic        overrun_o,
  output logic        timeout_o,
  output logic [7:0]  overrun_cnt_o
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);
  // The ACK state is entered one clock after the start pulse, so loading ACK_TIMEOUT-2
  // makes timeout_o rise exactly ACK_TIMEOUT clocks after the start pulse.
  localparam logic [TW-1:0] TMR_LOAD = TW'(ACK_TIMEOUT - 2);

  typedef enum logic [2:0] {
    IDLE, ADC_REQ, ADC_ACK, ADC_RUN, FILT, DAC_REQ, DAC_ACK, DAC_RUN
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          filt_first_q, filt_first_d;
  logic [15:0]   filt_data_q, filt_data_d;
  logic [15:0]   dac_data_q, dac_data_d;
  logic          overrun_q, overrun_d;
  logic          timeout_q, timeout_d;
  logic          slot, busy;

  assign slot  = (cnt_q == CNT_LAST);
  assign busy  = (state_q != IDLE);
  assign cnt_d = slot ? '0 : cnt_q + CW'(1);

  // Registers: free-running period counter plus all FSM-owned state
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      tmr_q        <= '0;
      filt_first_q <= 1'b0;
      filt_data_q  <= '0;
      dac_data_q   <= '0;
      overrun_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tmr_q        <= tmr_d;
      filt_first_q <= filt_first_d;
      filt_data_q  <= filt_data_d;
      dac_data_q   <= dac_data_d;
      overrun_q    <= overrun_d;
      timeout_q    <= timeout_d;
    end
  end

  // Next-state logic, sample/result latching and sticky flags
  always_comb begin
    state_d      = state_q;
    tmr_d        = tmr_q;
    filt_first_d = 1'b0;
    filt_data_d  = filt_data_q;
    dac_data_d   = dac_data_q;
    timeout_d    = timeout_q;
    overrun_d    = overrun_q | (slot & busy);
    case (state_q)
      IDLE: begin
        if (slot && enable_i) state_d = ADC_REQ;
      end
      ADC_REQ: begin
        tmr_d   = TMR_LOAD;
        state_d = ADC_ACK;
      end
      ADC_ACK: begin
        if (!adc_idle_i) begin
          state_d = ADC_RUN;
        end else if (tmr_q == '0) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      ADC_RUN: begin
        if (adc_idle_i) begin
          filt_data_d = adc_data_i;
          if (bypass_i) begin
            dac_data_d = mute_i ? 16'd0 : adc_data_i;
            state_d    = DAC_REQ;
          end else begin
            filt_first_d = 1'b1;
            state_d      = FILT;
          end
        end
      end
      FILT: begin
        if (filt_done_i) begin
          dac_data_d = mute_i ? 16'd0 : filt_result_i;
          state_d    = DAC_REQ;
        end
      end
      DAC_REQ: begin
        tmr_d   = TMR_LOAD;
        state_d = DAC_ACK;
      end
      DAC_ACK: begin
        if (!dac_idle_i) begin
          state_d = DAC_RUN;
        end else if (tmr_q == '0) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      DAC_RUN: begin
        if (dac_idle_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign adc_start_o  = (state_q == ADC_REQ);
  assign filt_start_o = filt_first_q;
  assign dac_start_o  = (state_q == DAC_REQ);
  assign filt_data_o  = filt_data_q;
  assign dac_data_o   = dac_data_q;
  assign busy_o       = busy;
  assign overrun_o    = overrun_q;
  assign timeout_o    = timeout_q;

`ifdef OVERRUN_COUNT_EN
  logic [7:0] ovr_cnt_q;

  // Dropped-slot counter, saturating at 255
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      ovr_cnt_q <= 8'd0;
    end else if (slot && busy && (ovr_cnt_q != 8'hFF)) begin
      ovr_cnt_q <= ovr_cnt_q + 8'd1;
    end
  end

  assign overrun_cnt_o = ovr_cnt_q;
`else
  assign overrun_cnt_o = 8'd0;
`endif

endmodule

// File: tb/tb_sample_sequencer.sv
// Bench for sample_sequencer: behavioural ADC/filter/DAC peripherals driven on the
// falling edge, a per-sample expected-word queue, and timing checks against the slot grid.
module tb_sample_sequencer;
  localparam int PERIOD      = 32;
  localparam int ACK_TIMEOUT = 15;

  logic        clk_i         = 1'b0;
  logic        reset_ni      = 1'b0;
  logic        enable_i      = 1'b0;
  logic        bypass_i      = 1'b0;
  logic        mute_i        = 1'b0;
  logic        adc_idle_i    = 1'b1;
  logic [15:0] adc_data_i    = 16'd0;
  logic        filt_done_i   = 1'b0;
  logic [15:0] filt_result_i = 16'd0;
  logic        dac_idle_i    = 1'b1;
  logic        adc_start_o, filt_start_o, dac_start_o, busy_o, overrun_o, timeout_o;
  logic [15:0] filt_data_o, dac_data_o;
  logic [7:0]  overrun_cnt_o;

  sample_sequencer #(.PERIOD(PERIOD), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .enable_i(enable_i), .bypass_i(bypass_i),
    .mute_i(mute_i), .adc_start_o(adc_start_o), .adc_idle_i(adc_idle_i),
    .adc_data_i(adc_data_i), .filt_start_o(filt_start_o), .filt_data_o(filt_data_o),
    .filt_done_i(filt_done_i), .filt_result_i(filt_result_i), .dac_start_o(dac_start_o),
    .dac_data_o(dac_data_o), .dac_idle_i(dac_idle_i), .busy_o(busy_o),
    .overrun_o(overrun_o), .timeout_o(timeout_o), .overrun_cnt_o(overrun_cnt_o)
  );

  always #10 clk_i = ~clk_i;

  // clocks since the last reset release
  int cyc = 0;
  always @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) cyc <= 0;
    else           cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // peripheral model configuration
  int          adc_len = 10, filt_len = 3, dac_len = 4;
  bit          adc_dead = 0, dac_dead = 0, adc_rand = 0, spur_en = 0;
  logic [15:0] adc_fixed = 16'h1234, filt_val = 16'hFF00;
  // model state and scoreboard
  int          adc_cnt = 0, filt_cnt = -1, dac_cnt = 0, n_dac = 0, dac_cyc = 0;
  logic [15:0] adc_last = 16'd0, dac_hold = 16'd0;
  logic [15:0] exp_q[$];
  int          start_q[$];

  // Peripherals react on the falling edge so the DUT sees stable inputs at posedge
  always @(negedge clk_i) begin
    filt_done_i = 1'b0;
    if (!reset_ni) begin
      adc_idle_i = 1'b1; dac_idle_i = 1'b1;
      adc_cnt = 0; filt_cnt = -1; dac_cnt = 0;
    end else begin
      if (adc_start_o) begin
        start_q.push_back(cyc);
        if (!adc_dead) begin
          adc_idle_i = 1'b0;
          adc_cnt    = adc_len;
          adc_data_i = 16'($urandom);
        end
      end else if (adc_cnt > 0) begin
        adc_cnt--;
        if (adc_cnt == 0) begin
          adc_last   = adc_rand ? 16'($urandom) : adc_fixed;
          adc_data_i = adc_last;
          adc_idle_i = 1'b1;
          exp_q.push_back(mute_i ? 16'd0 : (bypass_i ? adc_last : filt_val));
        end
      end

      if (filt_start_o) begin
        chk("filt_data", filt_data_o, adc_last);
        filt_cnt      = filt_len;
        filt_result_i = 16'($urandom);
      end
      if (filt_cnt == 0) begin
        filt_done_i   = 1'b1;
        filt_result_i = filt_val;
      end else if (spur_en && filt_cnt < 0 && $urandom_range(0, 5) == 0) begin
        filt_done_i   = 1'b1;
        filt_result_i = 16'($urandom);
      end
      if (filt_cnt >= 0) filt_cnt--;

      if (dac_start_o) begin
        n_dac++;
        dac_cyc = cyc;
        chk("dac_pending", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) chk("dac_data", dac_data_o, exp_q.pop_front());
        dac_hold = dac_data_o;
        if (!dac_dead) begin
          dac_idle_i = 1'b0;
          dac_cnt    = dac_len;
        end
      end else if (dac_cnt > 0) begin
        chk("dac_stable", dac_data_o, dac_hold);
        dac_cnt--;
        if (dac_cnt == 0) dac_idle_i = 1'b1;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic wait_cyc(input int n);
    int g = 0;
    while (cyc < n && g < 5000) begin @(negedge clk_i); g++; end
  endtask

  task automatic wait_starts(input int n, input int budget);
    int g = 0;
    while (start_q.size() < n && g < budget) begin @(negedge clk_i); g++; end
    chk("start_seen", start_q.size() >= n, 1'b1);
  endtask

  task automatic wait_dac(input int n, input int budget);
    int g = 0;
    while (n_dac < n && g < budget) begin @(negedge clk_i); g++; end
    chk("dac_seen", n_dac >= n, 1'b1);
  endtask

  function automatic int start_at(input int i);
    return (i < start_q.size()) ? start_q[i] : -1;
  endfunction

  task automatic check_gaps(input string tag, input int gap);
    for (int i = 1; i < start_q.size(); i++) chk(tag, start_q[i] - start_q[i-1], gap);
  endtask

  task automatic apply_reset();
    @(negedge clk_i);
    #3 reset_ni = 1'b0;
    #1;
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_starts", {adc_start_o, filt_start_o, dac_start_o}, 3'b000);
    chk("rst_flags", {overrun_o, timeout_o}, 2'b00);
    chk("rst_filt_data", filt_data_o, 16'd0);
    chk("rst_dac_data", dac_data_o, 16'd0);
    chk("rst_ovr_cnt", overrun_cnt_o, 8'd0);
    enable_i = 1'b0;
    exp_q.delete();
    start_q.delete();
    n_dac = 0;
    step(2);
    reset_ni = 1'b1;
  endtask

  task automatic drain();
    int g = 0;
    enable_i = 1'b0;
    while (busy_o && g < 200) begin @(negedge clk_i); g++; end
    chk("drain_idle", busy_o, 1'b0);
  endtask

  initial begin
    int t0;
    apply_reset();

    // bypass path, fixed sample, every slot used
    bypass_i = 1; mute_i = 0; adc_len = 10; adc_fixed = 16'h1234; dac_len = 4;
    enable_i = 1;
    wait_cyc(5 * PERIOD + 8);
    chk("t1_starts", start_q.size(), 5);
    chk("t1_first", start_at(0), PERIOD);
    check_gaps("t1_gap", PERIOD);
    chk("t1_overrun", overrun_o, 1'b0);
    chk("t1_dac_data", dac_data_o, 16'h1234);
    drain();
    chk("t1_delivered", n_dac, start_q.size());
    chk("t1_queue", exp_q.size(), 0);

    // filter path
    bypass_i = 0; filt_len = 3; filt_val = 16'hFF00;
    start_q.delete(); n_dac = 0; enable_i = 1;
    step(3 * PERIOD);
    drain();
    chk("t2_filt_data", filt_data_o, 16'h1234);
    chk("t2_dac_data", dac_data_o, 16'hFF00);
    chk("t2_ran", start_q.size() >= 2, 1'b1);
    chk("t2_delivered", n_dac, start_q.size());

    // randomized schedules that fit inside one slot
    for (int s = 0; s < 8; s++) begin
      bypass_i = 1'($urandom_range(0, 1));
      mute_i   = ($urandom_range(0, 3) == 0);
      adc_len  = $urandom_range(2, 12);
      filt_len = $urandom_range(0, 5);
      dac_len  = $urandom_range(2, 5);
      adc_rand = 1; spur_en = 1; filt_val = 16'($urandom);
      start_q.delete(); n_dac = 0; enable_i = 1;
      step(3 * PERIOD + $urandom_range(0, PERIOD - 1));
      drain();
      check_gaps("rnd_gap", PERIOD);
      chk("rnd_delivered", n_dac, start_q.size());
      chk("rnd_queue", exp_q.size(), 0);
      chk("rnd_overrun", overrun_o, 1'b0);
    end

    // mute on a full-scale sample
    mute_i = 1; bypass_i = 1; adc_rand = 0; adc_fixed = 16'h7FFF; spur_en = 0; adc_len = 6;
    start_q.delete(); n_dac = 0; enable_i = 1;
    wait_starts(1, 2 * PERIOD);
    drain();
    chk("mute_dac_pulsed", n_dac, 1);
    chk("mute_dac_data", dac_data_o, 16'd0);
    chk("mute_filt_data", filt_data_o, 16'h7FFF);
    mute_i = 0;

    // enable falling mid-sample: current sample completes, no new start
    bypass_i = 0; filt_len = 2; filt_val = 16'h0ABC; adc_fixed = 16'h0321;
    start_q.delete(); n_dac = 0; enable_i = 1;
    wait_starts(1, 2 * PERIOD);
    enable_i = 0;
    step(3 * PERIOD);
    chk("enfall_starts", start_q.size(), 1);
    chk("enfall_dac", n_dac, 1);
    chk("enfall_data", dac_data_o, 16'h0ABC);
    chk("enfall_idle", busy_o, 1'b0);

    // ADC never acknowledges
    apply_reset();
    adc_dead = 1; bypass_i = 1; enable_i = 1;
    wait_starts(1, 2 * PERIOD);
    t0 = start_at(0);
    chk("to_first", t0, PERIOD);
    wait_cyc(t0 + ACK_TIMEOUT - 1);
    chk("to_not_yet", timeout_o, 1'b0);
    chk("to_busy", busy_o, 1'b1);
    wait_cyc(t0 + ACK_TIMEOUT);
    chk("to_set", timeout_o, 1'b1);
    chk("to_idle", busy_o, 1'b0);
    wait_starts(2, 2 * PERIOD);
    chk("to_retry_gap", start_at(1) - start_at(0), PERIOD);
    drain();
    adc_dead = 0;
    chk("to_sticky", timeout_o, 1'b1);
    chk("to_no_overrun", overrun_o, 1'b0);

    // DAC never acknowledges
    apply_reset();
    dac_dead = 1; adc_len = 5; adc_fixed = 16'h0F0F; bypass_i = 1; enable_i = 1;
    wait_dac(1, 3 * PERIOD);
    t0 = dac_cyc;
    wait_cyc(t0 + ACK_TIMEOUT - 1);
    chk("dto_not_yet", timeout_o, 1'b0);
    wait_cyc(t0 + ACK_TIMEOUT);
    chk("dto_set", timeout_o, 1'b1);
    chk("dto_idle", busy_o, 1'b0);
    drain();
    dac_dead = 0;

    // conversion longer than a slot: every other slot dropped
    apply_reset();
    adc_len = 40; bypass_i = 1; dac_len = 3; adc_rand = 1; enable_i = 1;
    wait_cyc(2 * PERIOD - 2);
    chk("ovr_before", overrun_o, 1'b0);
    wait_cyc(2 * PERIOD);
    chk("ovr_after", overrun_o, 1'b1);
    wait_cyc(10 * PERIOD + 1);
    chk("ovr_starts", start_q.size(), 5);
    check_gaps("ovr_gap", 2 * PERIOD);
`ifdef OVERRUN_COUNT_EN
    chk("ovr_cnt", overrun_cnt_o, 8'd5);
`else
    chk("ovr_cnt", overrun_cnt_o, 8'd0);
`endif
    drain();
    chk("ovr_delivered", n_dac, start_q.size());
    chk("ovr_sticky", overrun_o, 1'b1);

    // reset while the DAC write is running
    adc_len = 5; dac_len = 20; adc_rand = 0; adc_fixed = 16'h1357;
    start_q.delete(); n_dac = 0; enable_i = 1;
    wait_dac(1, 3 * PERIOD);
    step(5);
    chk("pre_rst_busy", busy_o, 1'b1);
    chk("pre_rst_data", dac_data_o, 16'h1357);
    apply_reset();
    dac_len = 4; enable_i = 1;
    wait_starts(1, 2 * PERIOD);
    chk("rst_first_start", start_at(0), PERIOD);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
